spi_controller: RTL

//   SPI mode-0 write initiator; the controller end of the register-write link into spi_peripheral.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_controller_if.sv | 28 ++
 rtl/spi_sclk_tick.sv | 37 +++
 rtl/spi_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write link (controller and peripheral).
// Frame layout: R/W bit, ADDR_W address bits, then W data bits, MSB first.
package spi_pkg;

   localparam int ADDR_W      = 7;
   localparam int MAX_ADDRESS = 4;

   function automatic int frame_bits(input int w);
      return 1 + ADDR_W + w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } spi_state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Request-side bundle of spi_controller: write request handshake plus status pulses.
interface spi_controller_if
   import spi_pkg::*;
#(
   parameter int W = 8
) ();

   // req_* transfer on a clk edge where req_valid && req_ready; the requester holds
   // req_valid/addr/data stable until then, and req_ready never depends on req_valid.
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [W-1:0]      req_data;
   logic              done;
   logic              err;
   spi_state_e        dbg_state;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, done, err, dbg_state
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, done, err, dbg_state
   );

endinterface

// File: rtl/spi_sclk_tick.sv
// SCLK phase timer: pulses phase_tick once every HALF_PERIOD clk cycles while enabled.
module spi_sclk_tick #(
   parameter int HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clear,
   output logic phase_tick
);

   localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The tick must not depend on clear: clear is derived from the next state, which uses the tick.
   assign phase_tick = en && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !en || phase_tick) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one request per handshake becomes one nCS-framed write.
// Optional SPI_CTRL_ADDR_CHECK_EN rejects addresses above MAX_ADDRESS with an err pulse.
module spi_controller
   import spi_pkg::*;
#(
   parameter int W           = 8,
   parameter int HALF_PERIOD = 4,
   parameter int CS_GAP      = 8
) (
   input  logic clk,
   input  logic rst_n,
   spi_controller_if.slave req_if,
   output logic SCLK,
   output logic nCS,
   output logic COPI
);

   localparam int FRAME_BITS = frame_bits(W);
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   spi_state_e            state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d;
   logic ready_q, ready_d, done_q, done_d, err_q, err_d;
   logic accept, addr_ok, phase_tick, tick_en, tick_clear;

   assign accept = req_if.req_valid && ready_q;

`ifdef SPI_CTRL_ADDR_CHECK_EN
   assign addr_ok = (req_if.req_addr <= ADDR_W'(MAX_ADDRESS));
`else
   assign addr_ok = 1'b1;
`endif

   assign tick_en    = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign tick_clear = (state_d != state_q);

   spi_sclk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (tick_en),
      .clear      (tick_clear),
      .phase_tick (phase_tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sclk_d    = sclk_q;
      ncs_d     = ncs_q;
      copi_d    = copi_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && !addr_ok) begin
               err_d = 1'b1;
            end else if (accept) begin
               shreg_d   = {1'b1, req_if.req_addr, req_if.req_data};
               copi_d    = 1'b1;
               bit_cnt_d = BIT_W'(FRAME_BITS - 1);
               ncs_d     = 1'b0;
               sclk_d    = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // COPI only moves together with the falling SCLK, so it is stable across the rise.
            if (phase_tick && !sclk_q) begin
               sclk_d = 1'b1;
            end else if (phase_tick) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == '0) begin
                  copi_d  = 1'b0;
                  state_d = ST_HOLD;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  shreg_d   = shreg_q << 1;
                  copi_d    = shreg_q[FRAME_BITS-2];
               end
            end
         end
         ST_HOLD: begin
            if (phase_tick) begin
               ncs_d     = 1'b1;
               done_d    = 1'b1;
               gap_cnt_d = GAP_W'(CS_GAP - 1);
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         sclk_q    <= 1'b0;
         ncs_q     <= 1'b1;
         copi_q    <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sclk_q    <= sclk_d;
         ncs_q     <= ncs_d;
         copi_q    <= copi_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign SCLK             = sclk_q;
   assign nCS              = ncs_q;
   assign COPI             = copi_q;
   assign req_if.req_ready = ready_q;
   assign req_if.done      = done_q;
   assign req_if.err       = err_q;
   assign req_if.dbg_state = state_q;

endmodule
